// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Latency: MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu) busy cycles; mfhi/mflo/mthi/mtlo are single-cycle.
// Backpressure: busy is returned to the hazard unit; new starts and mthi/mtlo arriving while busy are dropped.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDOp,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MD_out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi_q, lo_q;
  logic        launch, done;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_abs, b_abs, div_b;
  logic [31:0] uq, ur, abs_q, abs_r;
  logic [31:0] res_hi, res_lo;
  logic        res_we;

  assign launch = (state == IDLE) && start && (MDOp >= OP_MULT) && (MDOp <= OP_DIVU);
  assign done   = (state == RUN) && (cnt == 4'd1);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: launch from IDLE, return when the counter expires
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = RUN;
      RUN:     if (done)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // Operand latch and cycle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= 4'd0;
      op_q <= 4'd0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
    end else if (launch) begin
      cnt  <= (MDOp <= OP_MULTU) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
      op_q <= MDOp;
      a_q  <= A;
      b_q  <= B;
    end else if (state == RUN) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Results from the latched operands; signed divide goes through magnitudes
  // so 0x80000000 / -1 wraps to 0x80000000 rather than hitting an overflow case.
  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    a_abs  = a_q[31] ? (32'd0 - a_q) : a_q;
    b_abs  = b_q[31] ? (32'd0 - b_q) : b_q;
    // divisor forced nonzero so the datapath never divides by zero; result is discarded anyway
    div_b  = (op_q == OP_DIV) ? b_abs : b_q;
    if (div_b == 32'd0) div_b = 32'd1;
    uq     = ((op_q == OP_DIV) ? a_abs : a_q) / div_b;
    ur     = ((op_q == OP_DIV) ? a_abs : a_q) % div_b;
    abs_q  = (a_q[31] ^ b_q[31]) ? (32'd0 - uq) : uq;
    abs_r  = a_q[31] ? (32'd0 - ur) : ur;
    res_we = 1'b1;
    res_hi = hi_q;
    res_lo = lo_q;
    case (op_q)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        res_hi = abs_r;
        res_lo = abs_q;
        res_we = (b_q != 32'd0);
      end
      OP_DIVU: begin
        res_hi = ur;
        res_lo = uq;
        res_we = (b_q != 32'd0);
      end
      default: res_we = 1'b0;
    endcase
  end

  // HI/LO update: commit on completion, direct writes only while idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (done) begin
      if (res_we) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end else if (state == IDLE) begin
      if (MDOp == OP_MTHI) hi_q <= A;
      if (MDOp == OP_MTLO) lo_q <= A;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

  // Read port for mfhi/mflo
  always_comb begin
    MD_out = 32'd0;
    if (MDOp == OP_MFHI) MD_out = hi_q;
    if (MDOp == OP_MFLO) MD_out = lo_q;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multi-cycle multiply/divide unit in the E stage of the 5-stage MIPS pipeline. It owns the HI/LO registers and executes mult/multu/div/divu/mfhi/mflo/mthi/mtlo. It drives `busy` back to the hazard unit. The hazard unit stalls any MD-class instruction in D while `start|busy` is high, so this block never receives a new MD op while busy.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy duration in cycles for div/divu (legal range 1..15)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- A  input  32  rs operand (already forwarded)
- B  input  32  rt operand (already forwarded)
- MDOp  input  4  op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 are treated as none
- start  input  1  one-cycle pulse, asserted with MDOp 1-4 by the E-stage controller
- busy  output  1  high while a mult/div is in flight
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register
- MD_out  output  32  read data for mfhi/mflo

Behaviour:
- Reset (reset=0, asynchronous): busy=0, HI=0, LO=0, cycle counter=0, latched operands=0, pending op=none. MD_out then follows HI/LO combinationally, so it is 0.
- States:
  - IDLE (busy=0).
  - RUN (busy=1; holds a counter, the latched A/B, and the latched op).
- Launch (IDLE, start=1, MDOp in 1..4):
  - At the clock edge: latch A, B and op; load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy rises the cycle after the start edge.
- RUN: the counter decrements on every edge.
  - On the edge where counter==1: commit the result to HI/LO, clear busy, go to IDLE.
  - busy is therefore high for exactly N cycles. New HI/LO values are visible in the first cycle busy=0.
- Results (computed from latched operands):
  - mult: {HI,LO} = signed 64-bit A*B.
  - multu: {HI,LO} = unsigned 64-bit A*B.
  - div: LO = signed quotient, truncated toward zero; HI = remainder, sign of dividend.
  - divu: LO = unsigned quotient, HI = unsigned remainder.
- Divide by zero (B==0, div/divu): full busy period still runs; HI and LO are left unchanged at commit.
- div of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0 (no trap).
- mthi/mtlo in IDLE: write A to HI/LO at the edge; busy stays 0; start is ignored.
- mfhi/mflo: MD_out = HI or LO, combinational in the same cycle. For any other MDOp, MD_out=0.
- start=1 while busy=1 is a protocol violation: ignore it; the in-flight op completes unchanged.
- mthi/mtlo while busy=1: ignored.
- start=1 with MDOp outside 1..4: ignored.
- Reset asserted mid-RUN: aborts immediately to the reset values; no commit.
- Back-to-back: a start in the first cycle after busy falls is accepted normally.

Test Plan:
- Reset, then `mult` A=0xFFFFFFFE, B=3, start pulse → busy high exactly 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- `multu` A=0xFFFFFFFF, B=0xFFFFFFFF → after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001.
- `div` A=0xFFFFFFF9 (-7), B=2 → busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Follow with `divu` A=7, B=0 → busy 10 cycles; HI/LO unchanged.
- `mthi` A=0x12345678, then `mflo` and `mfhi` → busy never rises; MD_out=old LO, then 0x12345678 in the same cycle as MDOp.
- Start `div`; in cycle 3 of busy apply MDOp=mtlo and start=1 with mult → both ignored; the div result commits at cycle 10.
- Start `mult`; drop reset to 0 at busy cycle 2 → busy=0, HI=LO=0 immediately; after reset release no late commit occurs.
